// File: rtl/fpu_req_issue_queue_pkg.sv
// Shared types for the FPU request issue queue: core op/rounding encodings,
// issue FSM states and the packed request record.
package fpu_req_issue_queue_pkg;

  typedef enum logic [2:0] {
    FPU_ADD  = 3'd0,
    FPU_SUB  = 3'd1,
    FPU_MUL  = 3'd2,
    FPU_DIV  = 3'd3,
    FPU_SQRT = 3'd4,
    FPU_MIN  = 3'd5,
    FPU_MAX  = 3'd6,
    FPU_CMP  = 3'd7
  } fpu_op_t;

  typedef enum logic [1:0] {
    RND_RNE = 2'd0,
    RND_RTZ = 2'd1,
    RND_RUP = 2'd2,
    RND_RDN = 2'd3
  } fpu_rnd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fpu_issue_state_t;

  localparam int FPU_REQ_FP_W = 32;

  typedef struct packed {
    fpu_op_t                 op;
    fpu_rnd_t                rmode;
    logic [FPU_REQ_FP_W-1:0] a;
    logic [FPU_REQ_FP_W-1:0] b;
  } fpu_req_t;

  // Flattened request width for an arbitrary operand width (op, rmode, a, b).
  function automatic int fpu_req_width(input int fp_w);
    return 3 + 2 + 2 * fp_w;
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Synchronous FIFO with registered occupancy; pushes while full and pops
// while empty are ignored so callers cannot corrupt the pointers.
module fpu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fpu_req_issue_queue.sv
// Queues FPU requests, issues them one at a time to the core with a one-cycle
// start strobe, and returns results (or a forced timeout) on a response port.
module fpu_req_issue_queue
  import fpu_req_issue_queue_pkg::*;
#(
  parameter int FP_WIDTH       = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [2:0]                  req_op,
  input  logic [1:0]                  req_rmode,
  input  logic [FP_WIDTH-1:0]         req_a,
  input  logic [FP_WIDTH-1:0]         req_b,
  output logic                        fpu_start,
  output logic [2:0]                  fpu_op,
  output logic [1:0]                  fpu_rmode,
  output logic [FP_WIDTH-1:0]         fpu_a,
  output logic [FP_WIDTH-1:0]         fpu_b,
  input  logic                        fpu_ready,
  input  logic [FP_WIDTH-1:0]         fpu_result,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [2:0]                  rsp_op,
  output logic [FP_WIDTH-1:0]         rsp_result,
  output logic                        rsp_timeout,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int REQ_W = fpu_req_width(FP_WIDTH);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  fpu_issue_state_t    state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  fpu_op_t             op_q, op_d;
  fpu_rnd_t            rmode_q, rmode_d;
  logic [FP_WIDTH-1:0] a_q, a_d;
  logic [FP_WIDTH-1:0] b_q, b_d;
  fpu_op_t             rsp_op_q, rsp_op_d;
  logic [FP_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [REQ_W-1:0]    fifo_wdata;
  logic [REQ_W-1:0]    fifo_rdata;
  logic [2:0]          head_op;
  logic [1:0]          head_rmode;
  logic [FP_WIDTH-1:0] head_a;
  logic [FP_WIDTH-1:0] head_b;

  // Ready comes only from the registered occupancy, so a same-cycle pop never frees a slot.
  assign req_ready  = ~fifo_full;
  assign fifo_push  = req_valid & req_ready;
  assign fifo_wdata = {req_op, req_rmode, req_a, req_b};

  assign head_op    = fifo_rdata[REQ_W-1 -: 3];
  assign head_rmode = fifo_rdata[REQ_W-4 -: 2];
  assign head_a     = fifo_rdata[2*FP_WIDTH-1 -: FP_WIDTH];
  assign head_b     = fifo_rdata[FP_WIDTH-1:0];

  fpu_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    op_d          = op_q;
    rmode_d       = rmode_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_op_d      = rsp_op_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    fifo_pop      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        if (fpu_ready) begin
          rsp_op_d      = op_q;
          rsp_result_d  = fpu_result;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES-1)) begin
          rsp_op_d      = op_q;
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Operands to the core only change when a new request is popped into ISSUE.
    if (fifo_pop) begin
      op_d    = fpu_op_t'(head_op);
      rmode_d = fpu_rnd_t'(head_rmode);
      a_d     = head_a;
      b_d     = head_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      op_q          <= FPU_ADD;
      rmode_q       <= RND_RNE;
      a_q           <= '0;
      b_q           <= '0;
      rsp_op_q      <= FPU_ADD;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      op_q          <= op_d;
      rmode_q       <= rmode_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rsp_op_q      <= rsp_op_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign fpu_start   = (state_q == ISSUE);
  assign rsp_valid   = (state_q == RESP);
  assign fpu_op      = op_q;
  assign fpu_rmode   = rmode_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
